// File: rtl/pong_ball_engine.sv
// Frame-synchronous ball physics and scoring engine for the Pong display path.
// The ball advances once per frame on the vsync rising edge. The engine also handles
// wall bounces, paddle hits, scoring and game-over sequencing.
module pong_ball_engine #(
    parameter int unsigned SCREEN_W       = 1024,
    parameter int unsigned SCREEN_H       = 768,
    parameter int unsigned BALL_SIZE      = 16,
    parameter int unsigned PADDLE_W       = 16,
    parameter int unsigned PADDLE_H       = 96,
    parameter int unsigned LEFT_PADDLE_X  = 32,
    parameter int unsigned RIGHT_PADDLE_X = 976,
    parameter int unsigned WIN_SCORE      = 9
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vs_in,
    input  logic        start,
    input  logic        serve,
    input  logic        pause,
    input  logic [1:0]  speed_selector,
    input  logic [10:0] left_palette_pos,
    input  logic [10:0] right_palette_pos,
    output logic [10:0] ball_xpos,
    output logic [10:0] ball_ypos,
    output logic [7:0]  score,
    output logic        point_scored,
    output logic        game_over,
    output logic        playing
);

    typedef enum logic [2:0] {
        IDLE,
        SERVE_WAIT,
        PLAY,
        UPD_Y,
        UPD_X,
        SCORED,
        OVER
    } state_t;

    localparam logic [10:0] CX    = 11'((SCREEN_W - BALL_SIZE) / 2);
    localparam logic [10:0] CY    = 11'((SCREEN_H - BALL_SIZE) / 2);
    localparam logic [11:0] YMAX  = 12'(SCREEN_H - BALL_SIZE);
    localparam logic [11:0] XMAX  = 12'(SCREEN_W - BALL_SIZE);
    localparam logic [11:0] LFACE = 12'(LEFT_PADDLE_X + PADDLE_W);
    localparam logic [11:0] RFACE = 12'(RIGHT_PADDLE_X - BALL_SIZE);
    localparam logic [11:0] PH    = 12'(PADDLE_H);
    localparam logic [11:0] BS    = 12'(BALL_SIZE);
    localparam logic [3:0]  WIN   = 4'(WIN_SCORE);

    state_t      state, state_n;
    logic        vs_q;
    logic        dx, dx_n;
    logic        dy, dy_n;
    logic        point_left, point_left_n;
    logic [10:0] x_n, y_n;
    logic [3:0]  score_l, score_l_n;
    logic [3:0]  score_r, score_r_n;
    logic [11:0] step_q, step_n;

    logic        tick;
    logic [11:0] step;
    logic [11:0] x12, y12;
    logic [11:0] pl12, pr12;
    logic        overlap_l, overlap_r;

    assign tick      = vs_in & ~vs_q;
    assign step      = {8'd0, {1'b0, speed_selector} + 3'd1, 1'b0};
    assign x12       = {1'b0, ball_xpos};
    assign y12       = {1'b0, ball_ypos};
    assign pl12      = {1'b0, left_palette_pos};
    assign pr12      = {1'b0, right_palette_pos};
    assign overlap_l = (y12 < pl12 + PH) && (y12 + BS > pl12);
    assign overlap_r = (y12 < pr12 + PH) && (y12 + BS > pr12);
    assign score     = {score_l, score_r};

    // Next-state and datapath update for the game sequencer
    always_comb begin
        state_n      = state;
        x_n          = ball_xpos;
        y_n          = ball_ypos;
        dx_n         = dx;
        dy_n         = dy;
        score_l_n    = score_l;
        score_r_n    = score_r;
        step_n       = step_q;
        point_left_n = point_left;
        case (state)
            IDLE, OVER: begin
                if (start) begin
                    state_n   = SERVE_WAIT;
                    score_l_n = '0;
                    score_r_n = '0;
                    x_n       = CX;
                    y_n       = CY;
                    dx_n      = 1'b1;
                    dy_n      = 1'b1;
                end
            end
            SERVE_WAIT: begin
                x_n = CX;
                y_n = CY;
                if (start) begin
                    score_l_n = '0;
                    score_r_n = '0;
                end else if (serve) begin
                    state_n = PLAY;
                end
            end
            PLAY: begin
                if (tick && !pause) state_n = UPD_Y;
            end
            UPD_Y: begin
                // The step is latched here so that the x update in the next cycle uses
                // the same step as this y update.
                step_n  = step;
                state_n = UPD_X;
                if (dy) begin
                    if (y12 + step >= YMAX) begin
                        y_n  = YMAX[10:0];
                        dy_n = 1'b0;
                    end else begin
                        y_n = 11'(y12 + step);
                    end
                end else begin
                    if (y12 < step) begin
                        y_n  = '0;
                        dy_n = 1'b1;
                    end else begin
                        y_n = 11'(y12 - step);
                    end
                end
            end
            UPD_X: begin
                state_n = PLAY;
                if (!dx) begin
                    // x - S < face is rewritten as x < face + S so it cannot wrap.
                    if (x12 >= LFACE && x12 < LFACE + step_q && overlap_l) begin
                        x_n  = LFACE[10:0];
                        dx_n = 1'b1;
                    end else if (x12 < step_q) begin
                        point_left_n = 1'b0;
                        state_n      = SCORED;
                    end else begin
                        x_n = 11'(x12 - step_q);
                    end
                end else begin
                    if (x12 <= RFACE && x12 + step_q > RFACE && overlap_r) begin
                        x_n  = RFACE[10:0];
                        dx_n = 1'b0;
                    end else if (x12 + step_q > XMAX) begin
                        point_left_n = 1'b1;
                        state_n      = SCORED;
                    end else begin
                        x_n = 11'(x12 + step_q);
                    end
                end
            end
            SCORED: begin
                x_n  = CX;
                y_n  = CY;
                dy_n = 1'b1;
                if (point_left) begin
                    dx_n      = 1'b1;
                    score_l_n = score_l + 4'd1;
                    state_n   = (score_l_n == WIN) ? OVER : SERVE_WAIT;
                end else begin
                    dx_n      = 1'b0;
                    score_r_n = score_r + 4'd1;
                    state_n   = (score_r_n == WIN) ? OVER : SERVE_WAIT;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // State, datapath and registered status outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            vs_q         <= 1'b1;
            ball_xpos    <= CX;
            ball_ypos    <= CY;
            dx           <= 1'b1;
            dy           <= 1'b1;
            score_l      <= '0;
            score_r      <= '0;
            step_q       <= '0;
            point_left   <= 1'b0;
            point_scored <= 1'b0;
            game_over    <= 1'b0;
            playing      <= 1'b0;
        end else begin
            state        <= state_n;
            vs_q         <= vs_in;
            ball_xpos    <= x_n;
            ball_ypos    <= y_n;
            dx           <= dx_n;
            dy           <= dy_n;
            score_l      <= score_l_n;
            score_r      <= score_r_n;
            step_q       <= step_n;
            point_left   <= point_left_n;
            point_scored <= (state_n == SCORED);
            game_over    <= (state_n == OVER);
            playing      <= (state_n == PLAY) || (state_n == UPD_Y) || (state_n == UPD_X);
        end
    end

endmodule

// File: tb/tb_pong_ball_engine.sv
// Directed self-checking bench for pong_ball_engine. The instance is built with
// WIN_SCORE = 2 so that a game-over can be reached quickly.
module tb_pong_ball_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        vs_in = 1'b0;
    logic        start = 1'b0;
    logic        serve = 1'b0;
    logic        pause = 1'b0;
    logic [1:0]  speed_selector = 2'd0;
    logic [10:0] left_palette_pos = 11'd0;
    logic [10:0] right_palette_pos = 11'd0;
    logic [10:0] ball_xpos;
    logic [10:0] ball_ypos;
    logic [7:0]  score;
    logic        point_scored;
    logic        game_over;
    logic        playing;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    pong_ball_engine #(.WIN_SCORE(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .vs_in             (vs_in),
        .start             (start),
        .serve             (serve),
        .pause             (pause),
        .speed_selector    (speed_selector),
        .left_palette_pos  (left_palette_pos),
        .right_palette_pos (right_palette_pos),
        .ball_xpos         (ball_xpos),
        .ball_ypos         (ball_ypos),
        .score             (score),
        .point_scored      (point_scored),
        .game_over         (game_over),
        .playing           (playing)
    );

    // Free-running clock
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    // One vsync pulse spanning a full position update and any score settle cycle
    task automatic tick_frame();
        vs_in = 1'b1;
        step();
        step();
        step();
        vs_in = 1'b0;
        step();
    endtask

    task automatic run_ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick_frame();
    endtask

    task automatic pulse_serve();
        serve = 1'b1;
        step();
        serve = 1'b0;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_x", ball_xpos, 12'd504);
        check("rst_y", ball_ypos, 12'd376);
        check("rst_score", score, 12'h000);
        check("rst_over", game_over, 12'd0);
        check("rst_play", playing, 12'd0);
        check("rst_pt", point_scored, 12'd0);
        rst = 1'b1;
        step();

        // Start: ball held at centre, ticks ignored until serve
        start = 1'b1;
        step();
        start = 1'b0;
        check("sw_play", playing, 12'd0);
        tick_frame();
        check("sw_hold_x", ball_xpos, 12'd504);
        check("sw_hold_y", ball_ypos, 12'd376);
        pulse_serve();
        check("serve_play", playing, 12'd1);

        // Single step at speed 0, with timing
        speed_selector = 2'd0;
        vs_in = 1'b1;
        step();
        check("ss_y_early", ball_ypos, 12'd376);
        step();
        check("ss_y", ball_ypos, 12'd378);
        check("ss_x_early", ball_xpos, 12'd504);
        step();
        check("ss_x", ball_xpos, 12'd506);
        vs_in = 1'b0;
        step();

        // Paused ticks do not move the ball
        pause = 1'b1;
        tick_frame();
        check("pause_x", ball_xpos, 12'd506);
        check("pause_y", ball_ypos, 12'd378);
        check("pause_play", playing, 12'd1);
        pause = 1'b0;
        step();

        // Bottom wall at speed 3
        speed_selector = 2'd3;
        run_ticks(46);
        check("bw_pre_y", ball_ypos, 12'd746);
        check("bw_pre_x", ball_xpos, 12'd874);
        tick_frame();
        check("bw_clamp_y", ball_ypos, 12'd752);
        check("bw_clamp_x", ball_xpos, 12'd882);
        tick_frame();
        check("bw_up_y", ball_ypos, 12'd744);

        // Right paddle hit with the paddle at the ball's height
        right_palette_pos = 11'd640;
        run_ticks(8);
        check("rp_pre_x", ball_xpos, 12'd954);
        check("rp_pre_y", ball_ypos, 12'd680);
        tick_frame();
        check("rp_hit_x", ball_xpos, 12'd960);
        check("rp_hit_y", ball_ypos, 12'd672);
        check("rp_score", score, 12'h000);
        tick_frame();
        check("rp_back_x", ball_xpos, 12'd952);
        check("rp_back_y", ball_ypos, 12'd664);

        // Asynchronous reset mid-game
        #2;
        rst = 1'b0;
        #1;
        check("mrst_x", ball_xpos, 12'd504);
        check("mrst_y", ball_ypos, 12'd376);
        check("mrst_score", score, 12'h000);
        check("mrst_over", game_over, 12'd0);
        check("mrst_play", playing, 12'd0);
        step();
        rst = 1'b1;
        step();

        // start beats serve in the same cycle from IDLE
        start = 1'b1;
        serve = 1'b1;
        step();
        start = 1'b0;
        serve = 1'b0;
        check("ss_prio_play", playing, 12'd0);
        step();
        check("ss_prio_hold", playing, 12'd0);
        pulse_serve();
        check("ss_prio_serve", playing, 12'd1);

        // Right miss with the paddle at the top: point to left
        right_palette_pos = 11'd0;
        run_ticks(63);
        check("rm_pre_x", ball_xpos, 12'd1008);
        check("rm_pre_y", ball_ypos, 12'd624);
        vs_in = 1'b1;
        step();
        step();
        check("rm_y", ball_ypos, 12'd616);
        check("rm_pt_early", point_scored, 12'd0);
        step();
        check("rm_pt", point_scored, 12'd1);
        check("rm_score_early", score, 12'h000);
        check("rm_scored_play", playing, 12'd0);
        vs_in = 1'b0;
        step();
        check("rm_pt_end", point_scored, 12'd0);
        check("rm_score", score, 12'h010);
        check("rm_cx", ball_xpos, 12'd504);
        check("rm_cy", ball_ypos, 12'd376);
        check("rm_over", game_over, 12'd0);
        tick_frame();
        check("rm_hold_x", ball_xpos, 12'd504);
        check("rm_hold_y", ball_ypos, 12'd376);
        pulse_serve();
        tick_frame();
        check("rm_dx_x", ball_xpos, 12'd512);
        check("rm_dy_y", ball_ypos, 12'd384);

        // Second left point reaches WIN_SCORE
        run_ticks(63);
        check("go_score", score, 12'h020);
        check("go_over", game_over, 12'd1);
        check("go_play", playing, 12'd0);
        pulse_serve();
        check("go_serve_over", game_over, 12'd1);
        check("go_serve_play", playing, 12'd0);
        tick_frame();
        check("go_hold_x", ball_xpos, 12'd504);
        start = 1'b1;
        step();
        start = 1'b0;
        check("go_restart_score", score, 12'h000);
        check("go_restart_over", game_over, 12'd0);

        // Back to OVER, then start and serve together
        pulse_serve();
        run_ticks(64);
        check("go2_score1", score, 12'h010);
        pulse_serve();
        run_ticks(64);
        check("go2_score2", score, 12'h020);
        check("go2_over", game_over, 12'd1);
        start = 1'b1;
        serve = 1'b1;
        step();
        start = 1'b0;
        serve = 1'b0;
        check("go2_ss_over", game_over, 12'd0);
        check("go2_ss_play", playing, 12'd0);
        check("go2_ss_score", score, 12'h000);
        step();
        check("go2_ss_hold", playing, 12'd0);
        pulse_serve();
        check("go2_serve", playing, 12'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
